// File: rtl/led_pattern_sequencer.sv
// Table-driven LED sequencer: steps through {pattern, dwell} words, holding each
// pattern for dwell+1 clocks, with loop/one-shot, direction, pause and live table writes.
module led_pattern_sequencer #(
  parameter int LED_W      = 8,
  parameter int DWELL_W    = 8,
  parameter int ADDR_W     = 3,
  parameter int DWELL_INIT = 'h80
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     dir,
  input  logic                     oneshot,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [LED_W+DWELL_W-1:0] wr_data,
  output logic [LED_W-1:0]         leds,
  output logic [ADDR_W-1:0]        addr,
  output logic                     busy,
  output logic                     done,
  output logic                     wrap
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int WORD_W = LED_W + DWELL_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [WORD_W-1:0]  table_q [DEPTH];
  logic [1:0]         state;
  logic [DWELL_W-1:0] count;
  logic [ADDR_W-1:0]  next_addr;
  logic [ADDR_W-1:0]  load_addr;
  logic               at_wrap;
  logic [WORD_W-1:0]  load_word;

  // Write-first bypass: a write landing on the same edge as a load of that
  // address feeds the new word straight into leds/count.
  always_comb begin
    next_addr = dir ? (addr - ADDR_W'(1)) : (addr + ADDR_W'(1));
    at_wrap   = dir ? (addr == '0) : (addr == ADDR_W'(DEPTH - 1));
    load_addr = (state == S_RUN) ? next_addr : '0;
    load_word = (wr_en && (wr_addr == load_addr)) ? wr_data : table_q[load_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= {LED_W'(1) << (i % LED_W), DWELL_W'(DWELL_INIT)};
      end
    end else if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      leds  <= '0;
      addr  <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        S_IDLE: begin
          leds  <= '0;
          addr  <= '0;
          count <= '0;
          if (en) begin
            state <= S_RUN;
            busy  <= 1'b1;
            leds  <= load_word[WORD_W-1:DWELL_W];
            count <= load_word[DWELL_W-1:0];
          end
        end
        S_RUN: begin
          // en low freezes everything so the remaining dwell resumes intact.
          if (en) begin
            if (count != '0) begin
              count <= count - DWELL_W'(1);
            end else if (at_wrap && oneshot) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              wrap  <= 1'b1;
            end else begin
              addr  <= next_addr;
              leds  <= load_word[WORD_W-1:DWELL_W];
              count <= load_word[DWELL_W-1:0];
              wrap  <= at_wrap;
            end
          end
        end
        S_DONE: begin
          if (!en) begin
            state <= S_IDLE;
            done  <= 1'b0;
            leds  <= '0;
            addr  <= '0;
            count <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          leds  <= '0;
          addr  <= '0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: table-driven run vectors plus hand-written
// sequences for one-shot, live writes, write-first, pause and mid-run reset.
module tb_led_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        dir = 1'b0;
  logic        oneshot = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [7:0]  leds;
  logic [2:0]  addr;
  logic        busy;
  logic        done;
  logic        wrap;

  led_pattern_sequencer #(
    .LED_W(8), .DWELL_W(8), .ADDR_W(3), .DWELL_INIT(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .oneshot(oneshot),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .leds(leds), .addr(addr), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Expected word layout: {busy, done, wrap, addr[2:0], leds[7:0]}
  typedef struct {
    logic        r;
    logic        e;
    logic        d;
    logic [13:0] exp;
  } vec_t;

  localparam logic [13:0] EX0 = '0;

  logic [13:0] exp_q[$];
  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [13:0] ex(input logic b, input logic dn, input logic wp,
                                     input logic [2:0] a, input logic [7:0] l);
    return {b, dn, wp, a, l};
  endfunction

  function automatic vec_t mk(input logic r, input logic e, input logic d,
                              input logic [13:0] x);
    vec_t v;
    v.r = r; v.e = e; v.d = d; v.exp = x;
    return v;
  endfunction

  task automatic cyc(input logic r_i, input logic e_i, input logic d_i, input logic o_i,
                     input logic w_i, input logic [2:0] wa_i, input logic [15:0] wd_i,
                     input logic [13:0] x, input string nm);
    logic [13:0] got;
    logic [13:0] want;
    rst = r_i; en = e_i; dir = d_i; oneshot = o_i;
    wr_en = w_i; wr_addr = wa_i; wr_data = wd_i;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    got  = {busy, done, wrap, addr, leds};
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got busy=%b done=%b wrap=%b addr=%0d leds=%h, want busy=%b done=%b wrap=%b addr=%0d leds=%h",
               nm, $time, got[13], got[12], got[11], got[10:8], got[7:0],
               want[13], want[12], want[11], want[10:8], want[7:0]);
    end
  endtask

  // Runs n cycles of an entry in ascending loop mode; wf marks a wrap on its first cycle.
  task automatic ent(input logic [2:0] a, input logic [7:0] l, input int n,
                     input logic wf, input string nm);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, ex(1'b1, 1'b0, wf && (k == 0), a, l), nm);
    end
  endtask

  initial begin
    // Ascending loop over the default walking-one table, dwell 2 -> 3 cycles each
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, EX0));
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 3; k++)
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, ex(1'b1, 1'b0, 1'b0, 3'(i), 8'(1 << i))));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, ex(1'b1, 1'b0, k == 0, 3'd0, 8'h01)));
    // Descending: 01 then 80 (wrap) down to 02, then 01 again without wrap
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, EX0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b1, ex(1'b1, 1'b0, 1'b0, 3'd0, 8'h01)));
    for (int j = 7; j >= 1; j--)
      for (int k = 0; k < 3; k++)
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, ex(1'b1, 1'b0, (j == 7) && (k == 0), 3'(j), 8'(1 << j))));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b1, ex(1'b1, 1'b0, 1'b0, 3'd0, 8'h01)));

    foreach (vecs[i])
      cyc(vecs[i].r, vecs[i].e, vecs[i].d, 1'b0, 1'b0, 3'd0, 16'h0000, vecs[i].exp, "table_run");

    // One-shot with all dwells rewritten to 0 while idle
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, EX0, "reset_os");
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'(i), {8'(1 << i), 8'h00}, EX0, "idle_write");
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, ex(1'b1, 1'b0, 1'b0, 3'(i), 8'(1 << i)), "oneshot_run");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, ex(1'b0, 1'b1, 1'b1, 3'd7, 8'h80), "done_enter");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, ex(1'b0, 1'b1, 1'b0, 3'd7, 8'h80), "done_hold");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, EX0, "done_to_idle");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, EX0, "idle_stay");

    // Write to the displayed entry: no effect now, used on the next pass
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, EX0, "reset_wr");
    ent(3'd0, 8'h01, 3, 1'b0, "pass1");
    ent(3'd1, 8'h02, 3, 1'b0, "pass1");
    ent(3'd2, 8'h04, 3, 1'b0, "pass1");
    ent(3'd3, 8'h08, 1, 1'b0, "pass1");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 16'hAA05, ex(1'b1, 1'b0, 1'b0, 3'd3, 8'h08), "write_current");
    ent(3'd3, 8'h08, 1, 1'b0, "write_current_hold");
    for (int i = 4; i < 8; i++) ent(3'(i), 8'(1 << i), 3, 1'b0, "pass1");
    ent(3'd0, 8'h01, 3, 1'b1, "pass2_wrap");
    ent(3'd1, 8'h02, 3, 1'b0, "pass2");
    ent(3'd2, 8'h04, 3, 1'b0, "pass2");
    ent(3'd3, 8'hAA, 6, 1'b0, "new_entry3");
    ent(3'd4, 8'h10, 3, 1'b0, "pass2");
    for (int i = 5; i < 8; i++) ent(3'(i), 8'(1 << i), 3, 1'b0, "pass2");
    ent(3'd0, 8'h01, 3, 1'b1, "pass3_wrap");
    ent(3'd1, 8'h02, 3, 1'b0, "pass3");
    ent(3'd2, 8'h04, 3, 1'b0, "pass3");
    // Write on the very edge that loads entry 3
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 16'h5501, ex(1'b1, 1'b0, 1'b0, 3'd3, 8'h55), "write_first");
    ent(3'd3, 8'h55, 1, 1'b0, "write_first_hold");
    ent(3'd4, 8'h10, 1, 1'b0, "pass3");

    // Pause after the first active cycle of entry 4, then finish its dwell
    for (int k = 0; k < 4; k++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, ex(1'b1, 1'b0, 1'b0, 3'd4, 8'h10), "pause_freeze");
    ent(3'd4, 8'h10, 2, 1'b0, "pause_resume");
    ent(3'd5, 8'h20, 1, 1'b0, "after_pause");

    // Reset mid-run after a table write restores the default table
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'hFF00, ex(1'b1, 1'b0, 1'b0, 3'd5, 8'h20), "write_e0");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, EX0, "reset_mid_run");
    ent(3'd0, 8'h01, 3, 1'b0, "restored");
    ent(3'd1, 8'h02, 1, 1'b0, "restored");

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
